// File: rtl/chip_7458_tester_if.sv
// Test-control and chip-pin bundle for chip_7458_tester.
// slave modport: the tester itself (takes start and chip samples, drives pins and verdict).
// master modport: the controlling side plus the attached chip or chip model.
interface chip_7458_tester_if #(
  parameter int ERR_W = 11
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [5:0]       drv_p1;
  logic [3:0]       drv_p2;
  logic             smp_p1y;
  logic             smp_p2y;
  logic [ERR_W-1:0] err_count;
  logic [9:0]       first_fail_vec;
  logic             first_fail_valid;

  modport slave (
    input  start, smp_p1y, smp_p2y,
    output busy, done, pass, drv_p1, drv_p2,
           err_count, first_fail_vec, first_fail_valid
  );

  modport master (
    output start, smp_p1y, smp_p2y,
    input  busy, done, pass, drv_p1, drv_p2,
           err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/chip_7458_tester.sv
// Purpose: sweeps all 1024 input vectors of a dual AND-OR chip and checks both outputs against a golden model.
// Latency: SETTLE_CYCLES+1 cycles per vector; done rises 1024*(SETTLE_CYCLES+1) cycles after start is accepted.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy.
// Ports: clk, rst_n (async active-low); bus (slave modport): start, busy, done, pass, drv_p1/drv_p2 (chip pins),
//        smp_p1y/smp_p2y (chip outputs), err_count, first_fail_vec, first_fail_valid.
// Optional: define CHIP_7458_TESTER_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module chip_7458_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  chip_7458_tester_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [9:0]       vec;
  logic [7:0]       cnt;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [9:0]       ffv_q;
  logic             ffvld_q;

  logic exp1;
  logic exp2;
  logic match;
  logic miss;
  logic last;

  assign exp1 = (&vec[2:0]) | (&vec[5:3]);
  assign exp2 = (&vec[7:6]) | (&vec[9:8]);

  assign match = (bus.smp_p1y == exp1) && (bus.smp_p2y == exp2);

  // Written as "match clears miss" so an unknown sample falls through as a mismatch.
  always_comb begin
    miss = 1'b1;
    if (match) miss = 1'b0;
  end

`ifdef CHIP_7458_TESTER_STOP_ON_FAIL_EN
  assign last = miss | (vec == 10'h3ff);
`else
  assign last = (vec == 10'h3ff);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec     <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= SETTLE;
            vec     <= '0;
            cnt     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) state <= CHECK;
        end
        CHECK: begin
          if (miss) begin
            if (!(&err_q)) err_q <= err_q + 1'b1;
            if (!ffvld_q) begin
              ffv_q   <= vec;
              ffvld_q <= 1'b1;
            end
          end
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // The count can only grow, so this vector's result settles the verdict.
            pass_q <= (err_q == '0) && !miss;
          end else begin
            vec   <= vec + 10'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.drv_p1           = vec[5:0];
  assign bus.drv_p2           = vec[9:6];
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvld_q;

endmodule

// File: tb/tb_chip_7458_tester.sv
// Bench for chip_7458_tester: instance A (SETTLE_CYCLES=2) with a chip model that can be forced faulty,
// instance B (SETTLE_CYCLES=1) with a chip model whose outputs lag one cycle.
module tb_chip_7458_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   fault = 0;  // 0 good chip, 1 p1y stuck-at-0, 2 p2y stuck-at-1

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chip_7458_tester_if #(.ERR_W(11)) ifa ();
  chip_7458_tester_if #(.ERR_W(11)) ifb ();

  chip_7458_tester #(.SETTLE_CYCLES(2), .ERR_W(11)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  chip_7458_tester #(.SETTLE_CYCLES(1), .ERR_W(11)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // Chip model, written pin by pin from the datasheet equations.
  function automatic logic sec1(input logic [5:0] p);
    logic a, b, c, d, e, f;
    {f, e, d, c, b, a} = p;
    return (a & b & c) | (d & e & f);
  endfunction
  function automatic logic sec2(input logic [3:0] p);
    logic a, b, c, d;
    {d, c, b, a} = p;
    return (a & b) | (c & d);
  endfunction

  assign ifa.smp_p1y = (fault == 1) ? 1'b0 : sec1(ifa.drv_p1);
  assign ifa.smp_p2y = (fault == 2) ? 1'b1 : sec2(ifa.drv_p2);

  logic b_y1 = 1'b0;
  logic b_y2 = 1'b0;
  always @(posedge clk) begin
    b_y1 <= sec1(ifb.drv_p1);
    b_y2 <= sec2(ifb.drv_p2);
  end
  assign ifb.smp_p1y = b_y1;
  assign ifb.smp_p2y = b_y2;

  typedef struct {
    int cyc; int err; int ffv; int ffvld; int pass; int p1; int p2; int acc;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_result(input string who, input exp_t e, input int now,
                              input logic busy, input logic pass, input logic [10:0] err,
                              input logic [9:0] ffv, input logic ffvld,
                              input logic [5:0] p1, input logic [3:0] p2);
    chk({who, "_done_cycle"}, 32'(now - e.acc), e.cyc);
    chk({who, "_busy"},       32'(busy),  0);
    chk({who, "_pass"},       32'(pass),  e.pass);
    chk({who, "_err_count"},  32'(err),   e.err);
    chk({who, "_ffv_valid"},  32'(ffvld), e.ffvld);
    if (e.ffvld != 0) chk({who, "_ffv"}, 32'(ffv), e.ffv);
    chk({who, "_drv_p1"},     32'(p1),    e.p1);
    chk({who, "_drv_p2"},     32'(p2),    e.p2);
  endtask

  // Scoreboard monitors: one per instance, triggered by the rising edge of done.
  logic done_qa = 1'b0;
  logic done_qb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ifa.done && !done_qa) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done: done rose with no run outstanding");
      end else begin
        e = exp_a.pop_front();
        check_result("a", e, cyc, ifa.busy, ifa.pass, ifa.err_count, ifa.first_fail_vec,
                     ifa.first_fail_valid, ifa.drv_p1, ifa.drv_p2);
      end
    end
    done_qa = ifa.done;
  end
  always @(negedge clk) begin
    exp_t e;
    if (ifb.done && !done_qb) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done: done rose with no run outstanding");
      end else begin
        e = exp_b.pop_front();
        check_result("b", e, cyc, ifb.busy, ifb.pass, ifb.err_count, ifb.first_fail_vec,
                     ifb.first_fail_valid, ifb.drv_p1, ifb.drv_p2);
      end
    end
    done_qb = ifb.done;
  end

  function automatic exp_t mk(input int c, input int err, input int ffv, input int ffvld,
                              input int pass, input int p1, input int p2);
    exp_t e;
    e.cyc = c; e.err = err; e.ffv = ffv; e.ffvld = ffvld; e.pass = pass;
    e.p1 = p1; e.p2 = p2; e.acc = 0;
    return e;
  endfunction

  // Pulse start on the selected instances; the accept edge is the posedge inside the pulse.
  task automatic launch(input bit go_a, input bit go_b, input exp_t ea, input exp_t eb);
    @(negedge clk);
    ifa.start = go_a;
    ifb.start = go_b;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    if (go_a) begin
      ea.acc = cyc; exp_a.push_back(ea);
      chk("a_busy_after_start", 32'(ifa.busy), 1);
      chk("a_done_after_start", 32'(ifa.done), 0);
    end
    if (go_b) begin
      eb.acc = cyc; exp_b.push_back(eb);
      chk("b_busy_after_start", 32'(ifb.busy), 1);
    end
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= lim) begin
      bad++;
      $display("FAIL run_timeout: outstanding a=%0d b=%0d after %0d cycles", exp_a.size(), exp_b.size(), n);
      exp_a.delete();
      exp_b.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_a_busy"},  32'(ifa.busy), 0);
    chk({tag, "_a_done"},  32'(ifa.done), 0);
    chk({tag, "_a_pass"},  32'(ifa.pass), 0);
    chk({tag, "_a_drv_p1"}, 32'(ifa.drv_p1), 0);
    chk({tag, "_a_drv_p2"}, 32'(ifa.drv_p2), 0);
    chk({tag, "_a_err"},   32'(ifa.err_count), 0);
    chk({tag, "_a_ffv"},   32'(ifa.first_fail_vec), 0);
    chk({tag, "_a_ffvld"}, 32'(ifa.first_fail_valid), 0);
    chk({tag, "_b_done"},  32'(ifb.done), 0);
    chk({tag, "_b_drv_p1"}, 32'(ifb.drv_p1), 0);
  endtask

  exp_t none;
  exp_t e_good;

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    none   = mk(0, 0, 0, 0, 0, 0, 0);
    e_good = mk(3072, 0, 0, 0, 1, 6'h3f, 4'hf);

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good chip on both; A gets a stray start 100 cycles into its run.
    launch(1'b1, 1'b1, e_good, mk(2048, 0, 0, 0, 1, 6'h3f, 4'hf));
    repeat (99) @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    chk("a_busy_after_stray_start", 32'(ifa.busy), 1);
    wait_drain(4000);
    chk("a_done_level_held", 32'(ifa.done), 1);

    // p1y stuck-at-0: 15 of 64 p1 patterns expect 1, times 16 p2 patterns.
    fault = 1;
`ifdef CHIP_7458_TESTER_STOP_ON_FAIL_EN
    launch(1'b1, 1'b0, mk(24, 1, 10'h007, 1, 0, 6'h07, 4'h0), none);
`else
    launch(1'b1, 1'b0, mk(3072, 240, 10'h007, 1, 0, 6'h3f, 4'hf), none);
`endif
    wait_drain(4000);

    // p2y stuck-at-1: 9 of 16 p2 patterns expect 0, times 64 p1 patterns.
    fault = 2;
`ifdef CHIP_7458_TESTER_STOP_ON_FAIL_EN
    launch(1'b1, 1'b0, mk(3, 1, 10'h000, 1, 0, 6'h00, 4'h0), none);
`else
    launch(1'b1, 1'b0, mk(3072, 576, 10'h000, 1, 0, 6'h3f, 4'hf), none);
`endif
    wait_drain(4000);

    // Reset in the middle of a good run, then a clean rerun.
    fault = 0;
    launch(1'b1, 1'b0, e_good, none);
    repeat (499) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_a.delete();
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(1'b1, 1'b0, e_good, none);
    wait_drain(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_7458_tester.md
Name: chip_7458_tester

Overview:
- Sequencer/checker for a dual AND-OR gate chip: two sections, p1y = (a&b&c)|(d&e&f) and p2y = (a&b)|(c&d).
- Walks all 1024 combinations of the chip's 10 inputs and drives them onto the chip pins.
- After a programmable settle delay, samples the chip's two outputs and compares them against an internal golden model.
- Reports mismatch count, first failing vector and a pass/fail verdict; sits between a test-control interface and the chip instance (or chip model).

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255.
- ERR_W, 11, width of err_count; saturates at all-ones.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled in IDLE and DONE.
- busy  output  1  high while a run is in progress.
- done  output  1  level; high in DONE until the next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- drv_p1  output  6  drive to p1a..p1f; bit0=p1a ... bit5=p1f.
- drv_p2  output  4  drive to p2a..p2d; bit0=p2a ... bit3=p2d.
- smp_p1y  input  1  chip output p1y.
- smp_p2y  input  1  chip output p2y.
- err_count  output  ERR_W  number of vectors with any output mismatch.
- first_fail_vec  output  10  vector index of the first mismatch.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec=0; settle cnt=0; busy=0, done=0, pass=0, drv_p1=0, drv_p2=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
- vec is a 10-bit register: drv_p1=vec[5:0], drv_p2=vec[9:6]. Both drive outputs come straight from registers, with no combinational path from inputs.
- Golden model: exp1 = (v0&v1&v2)|(v3&v4&v5); exp2 = (v6&v7)|(v8&v9).
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1:
  - next state SETTLE; vec=0; cnt=0; busy=1; done=0; pass=0.
  - err_count, first_fail_vec and first_fail_valid are all cleared.
- SETTLE: cnt increments each cycle; when cnt==SETTLE_CYCLES-1, next state is CHECK.
- CHECK (one cycle): samples smp_p1y and smp_p2y.
  - A mismatch is (smp_p1y!=exp1)|(smp_p2y!=exp2).
  - On mismatch, err_count increments, saturating at 2^ERR_W-1.
  - On mismatch with first_fail_valid=0, first_fail_vec=vec and first_fail_valid=1 are set.
  - If vec==1023: next state DONE.
  - Otherwise vec increments, cnt=0 and next state is SETTLE. The new vector appears on the drive pins in the first SETTLE cycle.
- DONE: busy=0; done=1; pass=(err_count==0); drive pins hold the last vector (1023).
- Timing: each vector occupies SETTLE_CYCLES+1 cycles.
  - With the default of 2, done rises 1024*3 = 3072 cycles after the start-accept edge.
- start while busy=1 is ignored, with no restart.
- An unknown or X sample counts as a mismatch.
- Reset asserted mid-run: all outputs return immediately to their reset values, with no partial verdict retained.
- There is no wrap-around: vec never advances past 1023.

Optional Feature:
- Macro CHIP_7458_TESTER_STOP_ON_FAIL_EN.
- Defined: the first CHECK with a mismatch goes straight to DONE, with err_count=1, pass=0, and drive pins holding the failing vector.
- Undefined: the full 1024-vector sweep always runs, and all mismatches are counted.

Test Plan:
- Correct chip model attached, SETTLE_CYCLES=2, pulse start:
  - busy=1 for 3072 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
- p1y stuck-at-0: err_count=240, first_fail_vec=10'h007, pass=0.
- p2y stuck-at-1: err_count=576, first_fail_vec=10'h000, pass=0.
- Correct model:
  - start re-pulsed at cycle 100 of a run → ignored, done still at cycle 3072.
  - rst_n low at cycle 500 → all outputs 0 within the same cycle.
  - Restart after release → full pass.
- CHIP_7458_TESTER_STOP_ON_FAIL_EN defined, p1y stuck-at-0: done after 24 cycles, err_count=1, first_fail_vec=10'h007, drv_p1=6'h07, drv_p2=0.
- SETTLE_CYCLES=1 with a model that has a 1-cycle output delay: pass=1, with done rising at 2048 cycles.
